// File: rtl/aes_key_expand_multi.sv
// AES key-expansion engine for 128/192/256-bit keys.
// Produces one 32-bit schedule word per cycle into local word storage,
// borrowing the design's shared S-box through sboxw/new_sboxw.
// Round keys are read combinationally by round index.
module aes_key_expand_multi #(
  parameter int MAX_NK = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [1:0]            keylen,
  input  logic [32*MAX_NK-1:0]  key,
  input  logic [3:0]            round,
  output logic [127:0]          round_key,
  output logic                  ready,
  output logic                  busy,
  output logic [3:0]            nr,
  output logic                  key_err,
  output logic [31:0]           sboxw,
  input  logic [31:0]           new_sboxw
);

  localparam int WORDS = 4 * (MAX_NK + 7);
  localparam int IW    = $clog2(WORDS);
  localparam logic [IW-1:0] ONE = 1;

  typedef enum logic {IDLE, EXPAND} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [2:0]      modc_q, modc_d;
  logic [7:0]      rcon_q, rcon_d;
  logic [3:0]      nk_q, nk_d;
  logic [3:0]      nr_q, nr_d;
  logic            ready_q, ready_d;
  logic            err_q, err_d;

  logic [31:0]     w_q [0:WORDS-1];

  logic [3:0]      nk_sel;
  logic [3:0]      nr_sel;
  logic            kl_ok;
  logic            accept;
  logic            reject;
  logic [31:0]     w_prev;
  logic [31:0]     w_back;
  logic [31:0]     new_word;
  logic [IW-1:0]   last_w;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  // Decode keylen into Nk/Nr and classify the init request
  always_comb begin
    nk_sel = 4'd4;
    nr_sel = 4'd10;
    kl_ok  = 1'b1;
    case (keylen)
      2'b00:   begin nk_sel = 4'd4; nr_sel = 4'd10; end
      2'b01:   begin nk_sel = 4'd6; nr_sel = 4'd12; end
      2'b10:   begin nk_sel = 4'd8; nr_sel = 4'd14; end
      default: kl_ok = 1'b0;
    endcase
    accept = init && kl_ok && (nk_sel <= 4'(MAX_NK));
    reject = init && !accept;
  end

  // Next schedule word from w[i-Nk], w[i-1] and the S-box result
  always_comb begin
    w_prev = w_q[i_q - ONE];
    w_back = w_q[i_q - IW'(nk_q)];
    last_w = IW'({nr_q, 2'b00}) + IW'(3);
    if (modc_q == 3'd0) begin
      new_word = w_back ^ rot_word(new_sboxw) ^ {rcon_q, 24'h0};
    end else if (nk_q == 4'd8 && modc_q == 3'd4) begin
      new_word = w_back ^ new_sboxw;
    end else begin
      new_word = w_back ^ w_prev;
    end
  end

  // Control next-state: accept/restart, reject pulse, per-word advance
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    modc_d  = modc_q;
    rcon_d  = rcon_q;
    nk_d    = nk_q;
    nr_d    = nr_q;
    ready_d = ready_q;
    err_d   = 1'b0;
    if (accept) begin
      state_d = EXPAND;
      i_d     = IW'(nk_sel);
      modc_d  = 3'd0;
      rcon_d  = 8'h01;
      nk_d    = nk_sel;
      nr_d    = nr_sel;
      ready_d = 1'b0;
    end else begin
      if (reject) err_d = 1'b1;
      if (state_q == EXPAND) begin
        i_d    = i_q + ONE;
        modc_d = (modc_q == 3'(nk_q - 4'd1)) ? 3'd0 : modc_q + 3'd1;
        if (modc_q == 3'd0) rcon_d = xtime(rcon_q);
        if (i_q == last_w) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
    end
  end

  // Control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      modc_q  <= 3'd0;
      rcon_q  <= 8'h01;
      nk_q    <= 4'd4;
      nr_q    <= 4'd10;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      modc_q  <= modc_d;
      rcon_q  <= rcon_d;
      nk_q    <= nk_d;
      nr_q    <= nr_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  // Word storage: key load on accept, one expanded word per EXPAND cycle
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int j = 0; j < MAX_NK; j++) begin
        if (4'(j) < nk_sel) w_q[j] <= key[32*MAX_NK-1-32*j -: 32];
      end
    end else if (state_q == EXPAND) begin
      w_q[i_q] <= new_word;
    end
  end

  // Round-key read; indices beyond the active schedule read as zero
  always_comb begin
    round_key = '0;
    if (round <= nr_q) begin
      for (int k = 0; k < 4; k++) begin
        round_key[127-32*k -: 32] = w_q[IW'({round, 2'b00}) + IW'(k)];
      end
    end
  end

  assign busy    = (state_q == EXPAND);
  assign ready   = ready_q;
  assign nr      = nr_q;
  assign key_err = err_q;
  assign sboxw   = busy ? w_prev : 32'h0;

endmodule

// File: tb/tb_aes_key_expand_multi.sv
// Testbench for aes_key_expand_multi: known-answer table, corner-case
// sequences and random keys against a FIPS-197 style reference schedule.
module tb_aes_key_expand_multi;

  logic         clk = 1'b0;
  logic         reset;
  logic         init;
  logic [1:0]   keylen;
  logic [255:0] key;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready, busy, key_err;
  logic [3:0]   nr;
  logic [31:0]  sboxw, new_sboxw;

  logic         init4;
  logic [1:0]   keylen4;
  logic [127:0] key4;
  logic [3:0]   round4;
  logic [127:0] round_key4;
  logic         ready4, busy4, key_err4;
  logic [3:0]   nr4;
  logic [31:0]  sboxw4, new_sboxw4;

  int checks = 0;
  int errors = 0;

  logic [31:0] mw [0:59];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  aes_key_expand_multi #(.MAX_NK(8)) dut (
    .clk(clk), .reset(reset), .init(init), .keylen(keylen), .key(key),
    .round(round), .round_key(round_key), .ready(ready), .busy(busy),
    .nr(nr), .key_err(key_err), .sboxw(sboxw), .new_sboxw(new_sboxw)
  );

  aes_key_expand_multi #(.MAX_NK(4)) dut4 (
    .clk(clk), .reset(reset), .init(init4), .keylen(keylen4), .key(key4),
    .round(round4), .round_key(round_key4), .ready(ready4), .busy(busy4),
    .nr(nr4), .key_err(key_err4), .sboxw(sboxw4), .new_sboxw(new_sboxw4)
  );

  // GF(2^8) arithmetic and the AES S-box built from inverse + affine map
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h0;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int n = 0; n < 8; n++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    logic [7:0] base = a;
    logic [7:0] e = 8'd254;
    logic [7:0] s;
    while (e != 0) begin
      if (e[0]) r = gmul(r, base);
      base = gmul(base, base);
      e = e >> 1;
    end
    if (a == 8'h0) r = 8'h0;
    s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  always_comb new_sboxw  = subword(sboxw);
  always_comb new_sboxw4 = subword(sboxw4);

  // Reference schedule, straight from the FIPS-197 loop
  task automatic model_expand(input logic [255:0] k, input int nk);
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int          total = 4 * (nk + 7);
    for (int i = 0; i < nk; i++) mw[i] = k[255-32*i -: 32];
    for (int i = nk; i < total; i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start(input logic [1:0] kl, input logic [255:0] k);
    @(negedge clk);
    init = 1'b1; keylen = kl; key = k;
    @(negedge clk);
    init = 1'b0;
  endtask

  task automatic start4(input logic [1:0] kl, input logic [127:0] k);
    @(negedge clk);
    init4 = 1'b1; keylen4 = kl; key4 = k;
    @(negedge clk);
    init4 = 1'b0;
  endtask

  // Count edges from the accepting edge until ready is seen
  task automatic wait_ready(input int lat, input string nm);
    int cnt = 0;
    while (!ready && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk(nm, 128'(cnt), 128'(lat));
  endtask

  task automatic check_all(input string tag, input int nrr);
    logic [127:0] exp;
    for (int r = 0; r < 16; r++) begin
      @(negedge clk);
      round = 4'(r);
      #1;
      exp = (r <= nrr) ? {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]} : 128'h0;
      chk($sformatf("%s_rk%0d", tag, r), round_key, exp);
    end
  endtask

  typedef struct {
    logic [1:0]   kl;
    logic [255:0] k;
    logic [3:0]   rnd;
    logic [127:0] exp;
    int           lat;
    logic [3:0]   nrv;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [255:0] rk;
    logic [1:0]   kl;
    int           nk, nrr, lat, cnt;

    vecs[0] = '{2'b00, K128, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 40, 4'd10};
    vecs[1] = '{2'b00, K128, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 40, 4'd10};
    vecs[2] = '{2'b00, K128, 4'd11, 128'h0,                                 40, 4'd10};
    vecs[3] = '{2'b01, K192, 4'd12, 128'he98ba06f448c773c8ecc720401002202, 46, 4'd12};
    vecs[4] = '{2'b10, K256, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 52, 4'd14};

    reset = 1'b1; init = 1'b0; keylen = 2'b00; key = '0; round = 4'd0;
    init4 = 1'b0; keylen4 = 2'b00; key4 = '0; round4 = 4'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 128'(ready), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_nr", 128'(nr), 128'(10));
    chk("rst_key_err", 128'(key_err), 128'(0));
    chk("rst_sboxw", 128'(sboxw), 128'(0));

    // Known-answer table
    for (int v = 0; v < 5; v++) begin
      start(vecs[v].kl, vecs[v].k);
      chk($sformatf("kat%0d_busy", v), 128'(busy), 128'(1));
      chk($sformatf("kat%0d_ready_low", v), 128'(ready), 128'(0));
      wait_ready(vecs[v].lat, $sformatf("kat%0d_latency", v));
      chk($sformatf("kat%0d_nr", v), 128'(nr), 128'(vecs[v].nrv));
      chk($sformatf("kat%0d_busy_done", v), 128'(busy), 128'(0));
      round = vecs[v].rnd;
      #1;
      chk($sformatf("kat%0d_rk", v), round_key, vecs[v].exp);
    end

    // Invalid keylen after an AES-128 run
    start(2'b00, K128);
    wait_ready(40, "inv_pre_latency");
    start(2'b11, K256);
    chk("inv_key_err_hi", 128'(key_err), 128'(1));
    chk("inv_ready_kept", 128'(ready), 128'(1));
    chk("inv_busy", 128'(busy), 128'(0));
    @(negedge clk);
    chk("inv_key_err_lo", 128'(key_err), 128'(0));
    chk("inv_nr", 128'(nr), 128'(10));
    round = 4'd10;
    #1;
    chk("inv_rk10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // MAX_NK=4 instance: 192/256 rejected, 128 works
    start4(2'b10, K128[255:128]);
    chk("n4_k256_err_hi", 128'(key_err4), 128'(1));
    chk("n4_k256_busy", 128'(busy4), 128'(0));
    @(negedge clk);
    chk("n4_k256_err_lo", 128'(key_err4), 128'(0));
    start4(2'b01, K128[255:128]);
    chk("n4_k192_err_hi", 128'(key_err4), 128'(1));
    start4(2'b00, K128[255:128]);
    chk("n4_k128_err", 128'(key_err4), 128'(0));
    cnt = 0;
    while (!ready4 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("n4_latency", 128'(cnt), 128'(40));
    round4 = 4'd10;
    #1;
    chk("n4_rk10", round_key4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Abort an AES-256 run with an AES-128 key
    start(2'b10, K256);
    repeat (19) @(negedge clk);
    chk("abort_busy_mid", 128'(busy), 128'(1));
    start(2'b00, K128);
    wait_ready(40, "abort_latency");
    chk("abort_nr", 128'(nr), 128'(10));
    model_expand(K128, 4);
    check_all("abort", 10);

    // Reset during expansion, then an AES-192 run
    start(2'b10, K256);
    repeat (9) @(negedge clk);
    chk("rst_mid_busy_before", 128'(busy), 128'(1));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_mid_ready", 128'(ready), 128'(0));
    chk("rst_mid_busy", 128'(busy), 128'(0));
    chk("rst_mid_sboxw", 128'(sboxw), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    start(2'b01, K192);
    wait_ready(46, "post_rst_latency");
    model_expand(K192, 6);
    check_all("post_rst", 12);

    // init held for three edges: timing counts from the last one
    rk = {$urandom, $urandom, $urandom, $urandom, 128'h0};
    @(negedge clk);
    init = 1'b1; keylen = 2'b00; key = rk;
    repeat (3) @(negedge clk);
    init = 1'b0;
    wait_ready(40, "held_latency");
    model_expand(rk, 4);
    check_all("held", 10);

    // Random keys against the reference schedule
    for (int n = 0; n < 12; n++) begin
      kl  = 2'($urandom_range(0, 2));
      nk  = 4 + 2 * int'(kl);
      nrr = nk + 6;
      lat = 4 * (nrr + 1) - nk;
      rk  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      start(kl, rk);
      wait_ready(lat, $sformatf("rnd%0d_latency", n));
      chk($sformatf("rnd%0d_nr", n), 128'(nr), 128'(nrr));
      chk($sformatf("rnd%0d_sboxw_idle", n), 128'(sboxw), 128'(0));
      model_expand(rk, nk);
      check_all($sformatf("rnd%0d", n), nrr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
